i2s_tx_scheduler: RTL and testbench

//  Sequencer and arbiter in front of the I2S transmitter. Generates the BCLK/LRCLK timebase and
//  the one-clk CBrise/CBfall strobes from clk. Shares the transmitter between two sample

---
 rtl/i2s_tx_scheduler_pkg.sv | 18 +
 rtl/i2s_tx_scheduler_if.sv | 37 +++
 rtl/i2s_tx_scheduler_clk_gen.sv | 67 ++++++
 rtl/i2s_tx_scheduler.sv | 133 +++++++++++++
 tb/tb_i2s_tx_scheduler.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/i2s_tx_scheduler_pkg.sv
// Shared definitions for the I2S transmit scheduler: FSM state encodings,
// grant source constants and the default frame width.
package i2s_pkg;

    typedef enum logic [2:0] {
        S_WAIT = 3'd0,
        S_ARB  = 3'd1,
        S_LOAD = 3'd2,
        S_ACK  = 3'd3,
        S_HOLD = 3'd4
    } state_e;

    localparam logic SRC_HOST = 1'b0;
    localparam logic SRC_TONE = 1'b1;

    localparam int DEFAULT_DATA_BITS = 32;

endpackage

// File: rtl/i2s_tx_scheduler_if.sv
// Signal bundle between the sample sources / transmitter and the scheduler.
// master = surrounding system (sources, transmitter, control), slave = scheduler.
interface i2s_tx_scheduler_if #(
    parameter int DATA_BITS = 32,
    parameter int UCNT_W    = 16
);
    logic                 en;
    logic                 s1_pri;
    logic [DATA_BITS-1:0] s0_data;
    logic                 s0_valid;
    logic                 s0_pop;
    logic [DATA_BITS-1:0] s1_data;
    logic                 s1_valid;
    logic                 s1_pop;
    logic                 xmit_rdy;
    logic                 xmit_ack;
    logic [DATA_BITS-1:0] sample;
    logic                 lrclk;
    logic                 cbclk;
    logic                 cb_rise;
    logic                 cb_fall;
    logic                 grant;
    logic                 underrun;
    logic [UCNT_W-1:0]    urun_cnt;

    modport master (
        output en, s1_pri, s0_data, s0_valid, s1_data, s1_valid, xmit_rdy,
        input  s0_pop, s1_pop, xmit_ack, sample, lrclk, cbclk, cb_rise, cb_fall,
               grant, underrun, urun_cnt
    );

    modport slave (
        input  en, s1_pri, s0_data, s0_valid, s1_data, s1_valid, xmit_rdy,
        output s0_pop, s1_pop, xmit_ack, sample, lrclk, cbclk, cb_rise, cb_fall,
               grant, underrun, urun_cnt
    );
endinterface

// File: rtl/i2s_tx_scheduler_clk_gen.sv
// BCLK/LRCLK timebase. cbclk toggles every BCLK_DIV clks; cb_rise/cb_fall are
// registered alongside cbclk so each strobe is high in the cycle cbclk has
// just changed. lrclk toggles on the cb_fall that completes NB bit periods.
module i2s_clk_gen #(
    parameter int BCLK_DIV = 4,
    parameter int NB       = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic cbclk_o,
    output logic lrclk_o,
    output logic cb_rise_o,
    output logic cb_fall_o
);
    localparam int DW = $clog2(BCLK_DIV);
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(BCLK_DIV - 1);
    localparam logic [BW-1:0] BIT_MAX = BW'(NB - 1);

    logic [DW-1:0] div_cnt_q;
    logic [BW-1:0] bit_cnt_q;
    logic          cbclk_q;
    logic          lrclk_q;
    logic          cb_rise_q;
    logic          cb_fall_q;

    // Divider, bit counter and clock outputs; en=0 parks everything at zero.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (rst || !en_i) begin
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            cbclk_q   <= 1'b0;
            lrclk_q   <= 1'b0;
            cb_rise_q <= 1'b0;
            cb_fall_q <= 1'b0;
        end else begin
            cb_rise_q <= 1'b0;
            cb_fall_q <= 1'b0;
            if (div_cnt_q == DIV_MAX) begin
                div_cnt_q <= '0;
                cbclk_q   <= ~cbclk_q;
                if (!cbclk_q) begin
                    cb_rise_q <= 1'b1;
                end else begin
                    cb_fall_q <= 1'b1;
                    if (bit_cnt_q == BIT_MAX) begin
                        bit_cnt_q <= '0;
                        lrclk_q   <= ~lrclk_q;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
            end else begin
                div_cnt_q <= div_cnt_q + 1'b1;
            end
        end
    end

    assign cbclk_o   = cbclk_q;
    assign lrclk_o   = lrclk_q;
    assign cb_rise_o = cb_rise_q;
    assign cb_fall_o = cb_fall_q;

endmodule

// File: rtl/i2s_tx_scheduler.sv
// I2S transmit scheduler: timebase plus a two-source arbiter that hands the
// transmitter one word per xmit_rdy rising edge (WAIT->ARB->LOAD->ACK->HOLD).
// Build option: I2S_SCHED_HOLD_EN defined repeats the last word on underrun;
// undefined sends silence (zero) instead.
module i2s_tx_scheduler
    import i2s_pkg::*;
#(
    parameter int DATA_BITS = DEFAULT_DATA_BITS,
    parameter int BCLK_DIV  = 4,
    parameter int UCNT_W    = 16
) (
    input logic          clk,
    input logic          rst,
    i2s_tx_scheduler_if.slave bus
);
    state_e               state_q, state_d;
    logic                 rdy_q;
    logic                 sel_q, sel_d;
    logic                 none_q, none_d;
    logic [DATA_BITS-1:0] sample_q;
    logic                 grant_q;
    logic [UCNT_W-1:0]    urun_cnt_q;
    logic                 rdy_rise;
    logic                 load_act;

    i2s_clk_gen #(
        .BCLK_DIV (BCLK_DIV),
        .NB       (DATA_BITS / 2)
    ) u_clk_gen (
        .clk       (clk),
        .rst       (rst),
        .en_i      (bus.en),
        .cbclk_o   (bus.cbclk),
        .lrclk_o   (bus.lrclk),
        .cb_rise_o (bus.cb_rise),
        .cb_fall_o (bus.cb_fall)
    );

    assign rdy_rise = bus.xmit_rdy && !rdy_q;
    assign load_act = bus.en && (state_q == S_LOAD);

    // Edge register for xmit_rdy; cleared while disabled so a level already high at enable counts as a rise.
    always_ff @(posedge clk) begin
        if (rst || !bus.en) rdy_q <= 1'b0;
        else                rdy_q <= bus.xmit_rdy;
    end

    // FSM state register; disable forces the idle state.
    always_ff @(posedge clk) begin
        if (rst || !bus.en) state_q <= S_WAIT;
        else                state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        // NOTE: defaulting every always_comb output first keeps unlisted paths from inferring latches.
        state_d = state_q;
        case (state_q)
            S_WAIT:  if (rdy_rise) state_d = S_ARB;
            S_ARB:   state_d = S_LOAD;
            S_LOAD:  state_d = S_ACK;
            S_ACK:   state_d = S_HOLD;
            S_HOLD:  if (!bus.xmit_rdy) state_d = S_WAIT;
            default: state_d = S_WAIT;
        endcase
    end

    // FSM outputs: pops/underrun only in LOAD, acknowledge only in ACK.
    always_comb begin
        bus.s0_pop   = 1'b0;
        bus.s1_pop   = 1'b0;
        bus.underrun = 1'b0;
        bus.xmit_ack = 1'b0;
        if (load_act) begin
            bus.underrun = none_q;
            bus.s0_pop   = !none_q && (sel_q == SRC_HOST);
            bus.s1_pop   = !none_q && (sel_q == SRC_TONE);
        end
        if (bus.en && state_q == S_ACK) bus.xmit_ack = 1'b1;
    end

    // Priority decision, evaluated every cycle but captured only in ARB.
    always_comb begin
        sel_d  = SRC_HOST;
        none_d = 1'b0;
        if (bus.s1_pri) begin
            if (bus.s1_valid)      sel_d = SRC_TONE;
            else if (bus.s0_valid) sel_d = SRC_HOST;
            else                   none_d = 1'b1;
        end else begin
            if (bus.s0_valid)      sel_d = SRC_HOST;
            else if (bus.s1_valid) sel_d = SRC_TONE;
            else                   none_d = 1'b1;
        end
    end

    // Arbitration result latch; s1_pri and valids are only looked at in ARB.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q  <= SRC_HOST;
            none_q <= 1'b0;
        end else if (bus.en && state_q == S_ARB) begin
            sel_q  <= sel_d;
            none_q <= none_d;
        end
    end

    // Sample/grant load and saturating underrun counter; urun_cnt survives en=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q   <= '0;
            grant_q    <= SRC_HOST;
            urun_cnt_q <= '0;
        end else if (load_act) begin
            if (none_q) begin
                if (urun_cnt_q != '1) urun_cnt_q <= urun_cnt_q + 1'b1;
`ifdef I2S_SCHED_HOLD_EN
                sample_q <= sample_q;
`else
                sample_q <= '0;
`endif
            end else begin
                sample_q <= (sel_q == SRC_TONE) ? bus.s1_data : bus.s0_data;
                grant_q  <= sel_q;
            end
        end
    end

    assign bus.sample   = sample_q;
    assign bus.grant    = grant_q;
    assign bus.urun_cnt = urun_cnt_q;

endmodule

// File: tb/tb_i2s_tx_scheduler.sv
// Self-checking bench for i2s_tx_scheduler: timebase measurement, a table of
// fetch vectors with a scoreboard queue, plus reset-in-LOAD and en-drop sequences.
// Honours I2S_SCHED_HOLD_EN for the underrun sample expectation.
module tb_i2s_tx_scheduler;

    localparam int DB = 32;
    localparam int UW = 2;
`ifdef I2S_SCHED_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    typedef struct {
        logic          s0v;
        logic [DB-1:0] d0;
        logic          s1v;
        logic [DB-1:0] d1;
        logic          pri;
        int            src;   // expected winner: 0 = s0, 1 = s1, 2 = none
    } vec_t;

    typedef struct {
        logic          pop0;
        logic          pop1;
        logic          ur;
        logic [DB-1:0] sample;
        logic          grant;
        logic [UW-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    exp_t          sb[$];
    logic [DB-1:0] m_sample = '0;
    logic          m_grant  = 1'b0;
    logic [UW-1:0] m_cnt    = '0;

    i2s_tx_scheduler_if #(.DATA_BITS(DB), .UCNT_W(UW)) bus ();

    i2s_tx_scheduler #(
        .DATA_BITS (DB),
        .BCLK_DIV  (4),
        .UCNT_W    (UW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_fetch(input vec_t v, input string tag);
        exp_t e, got;
        int   pop_cyc, ack_cyc, acks, strobes;
        logic g0, g1, gu;
        logic [DB-1:0] cap_sample;
        logic          cap_grant;
        logic [UW-1:0] cap_cnt;
        bus.s0_valid = v.s0v;
        bus.s0_data  = v.d0;
        bus.s1_valid = v.s1v;
        bus.s1_data  = v.d1;
        bus.s1_pri   = v.pri;
        e.pop0 = (v.src == 0);
        e.pop1 = (v.src == 1);
        e.ur   = (v.src == 2);
        if (v.src == 2) begin
            if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
            if (!HOLD) m_sample = '0;
        end else begin
            m_sample = (v.src == 1) ? v.d1 : v.d0;
            m_grant  = (v.src == 1);
        end
        e.sample = m_sample;
        e.grant  = m_grant;
        e.cnt    = m_cnt;
        sb.push_back(e);
        bus.xmit_rdy = 1'b1;
        pop_cyc = 0; ack_cyc = 0; acks = 0; strobes = 0;
        g0 = 1'b0; g1 = 1'b0; gu = 1'b0;
        cap_sample = '0; cap_grant = 1'b0; cap_cnt = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.s0_pop || bus.s1_pop || bus.underrun) begin
                strobes++;
                if (pop_cyc == 0) pop_cyc = c;
                g0 = g0 | bus.s0_pop;
                g1 = g1 | bus.s1_pop;
                gu = gu | bus.underrun;
            end
            if (bus.xmit_ack) begin
                acks++;
                if (ack_cyc == 0) begin
                    ack_cyc    = c;
                    cap_sample = bus.sample;
                    cap_grant  = bus.grant;
                    cap_cnt    = bus.urun_cnt;
                end
            end
            if (c == 3) bus.xmit_rdy = 1'b0;
        end
        check({tag, "_pop_latency"}, pop_cyc, 2);
        check({tag, "_ack_latency"}, ack_cyc, 3);
        check({tag, "_ack_count"}, acks, 1);
        check({tag, "_strobe_count"}, strobes, 1);
        if (ack_cyc == 0 || sb.size() == 0) begin
            check({tag, "_ack_timeout"}, 0, 1);
            sb.delete();
        end else begin
            got = sb.pop_front();
            check({tag, "_s0_pop"}, g0, got.pop0);
            check({tag, "_s1_pop"}, g1, got.pop1);
            check({tag, "_underrun"}, gu, got.ur);
            check({tag, "_sample"}, cap_sample, got.sample);
            check({tag, "_grant"}, cap_grant, got.grant);
            check({tag, "_urun_cnt"}, cap_cnt, got.cnt);
        end
    endtask

    initial begin
        vec_t vecs[12];
        vec_t v;
        int   n, found, bad, last_rise, last_lr, lr_toggles, ticks;
        logic prev_cb, prev_lr;

        vecs[0]  = '{1'b1, 32'hA5A5_1234, 1'b0, 32'h0BAD_0BAD, 1'b0, 0};
        vecs[1]  = '{1'b1, 32'h1111_0000, 1'b1, 32'hBEEF_CAFE, 1'b1, 1};
        vecs[2]  = '{1'b1, 32'h2222_3333, 1'b1, 32'h4444_5555, 1'b0, 0};
        vecs[3]  = '{1'b0, 32'h6666_7777, 1'b1, 32'h0000_FFFF, 1'b0, 1};
        vecs[4]  = '{1'b0, 32'h8888_9999, 1'b0, 32'hAAAA_BBBB, 1'b1, 2};
        vecs[5]  = '{1'b1, 32'h1357_9BDF, 1'b0, 32'hCCCC_DDDD, 1'b1, 0};
        vecs[6]  = '{1'b0, 32'h1, 1'b0, 32'h2, 1'b0, 2};
        vecs[7]  = '{1'b0, 32'h3, 1'b0, 32'h4, 1'b1, 2};
        vecs[8]  = '{1'b0, 32'h5, 1'b0, 32'h6, 1'b0, 2};
        vecs[9]  = '{1'b0, 32'h7, 1'b0, 32'h8, 1'b1, 2};
        vecs[10] = '{1'b0, 32'h9, 1'b0, 32'hA, 1'b0, 2};
        vecs[11] = '{1'b1, 32'h0F0F_0F0F, 1'b1, 32'hCAFE_F00D, 1'b1, 1};

        bus.en = 1'b0; bus.s1_pri = 1'b0; bus.xmit_rdy = 1'b0;
        bus.s0_valid = 1'b0; bus.s0_data = '0; bus.s1_valid = 1'b0; bus.s1_data = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_sample", bus.sample, 0);
        check("rst_outputs", {bus.s0_pop, bus.s1_pop, bus.xmit_ack, bus.lrclk, bus.cbclk,
                              bus.cb_rise, bus.cb_fall, bus.grant, bus.underrun}, 0);
        check("rst_urun_cnt", bus.urun_cnt, 0);
        rst = 1'b0;
        @(negedge clk);

        // Timebase: first rise latency, BCLK period, LRCLK half period and alignment.
        bus.en = 1'b1;
        n = 0; found = 0;
        for (int i = 1; i <= 20 && found == 0; i++) begin
            @(negedge clk);
            if (bus.cb_rise) begin found = 1; n = i; end
        end
        check("first_rise_latency", n, 4);
        bad = 0; last_rise = 0; last_lr = 0; lr_toggles = 0;
        prev_cb = bus.cbclk; prev_lr = bus.lrclk;
        for (int t = 1; t <= 600; t++) begin
            @(negedge clk);
            if (bus.cb_rise !== (bus.cbclk && !prev_cb)) bad++;
            if (bus.cb_fall !== (!bus.cbclk && prev_cb)) bad++;
            if (bus.cb_rise) begin
                if (t - last_rise != 8) bad++;
                last_rise = t;
            end
            if (bus.lrclk !== prev_lr) begin
                if (!bus.cb_fall) bad++;
                if (lr_toggles > 0 && t - last_lr != 128) bad++;
                last_lr = t;
                lr_toggles++;
            end
            prev_cb = bus.cbclk; prev_lr = bus.lrclk;
        end
        check("timebase_errors", bad, 0);
        check("lr_toggle_seen", (lr_toggles >= 4), 1);

        // Fetch table.
        for (int i = 0; i < 12; i++) run_fetch(vecs[i], $sformatf("vec%0d", i));
        check("scoreboard_empty", sb.size(), 0);

        // Reset asserted while in LOAD.
        bus.s0_valid = 1'b1; bus.s0_data = 32'hDEAD_BEEF; bus.s1_valid = 1'b0; bus.s1_pri = 1'b0;
        bus.xmit_rdy = 1'b1;
        repeat (2) @(negedge clk);
        check("rstload_pop_seen", bus.s0_pop, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rstload_ack", bus.xmit_ack, 0);
        check("rstload_pops", {bus.s0_pop, bus.s1_pop}, 0);
        check("rstload_sample", bus.sample, 0);
        check("rstload_clocks", {bus.cbclk, bus.lrclk}, 0);
        check("rstload_urun_cnt", bus.urun_cnt, 0);
        rst = 1'b0; bus.xmit_rdy = 1'b0;
        m_sample = '0; m_grant = 1'b0; m_cnt = '0;
        ticks = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.s0_pop || bus.s1_pop || bus.xmit_ack) ticks++;
        end
        check("rstload_no_repop", ticks, 0);

        // en dropped mid-frame after one underrun.
        v = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2};
        run_fetch(v, "pre_en");
        repeat (37) @(negedge clk);
        bus.en = 1'b0;
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.cb_rise || bus.cb_fall || bus.cbclk || bus.lrclk || bus.xmit_ack) bad++;
        end
        check("en_off_quiet", bad, 0);
        check("en_off_urun_kept", bus.urun_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
